// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and state types for the UART command-line parser.
// The lowercase command-letter option is enabled by defining CMD_LOWERCASE_EN.
package uart_cmd_pkg;

  localparam logic [2:0] CMD_NONE      = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_PAUSE     = 3'd2;
  localparam logic [2:0] CMD_CANCEL    = 3'd3;
  localparam logic [2:0] CMD_SET_TIME  = 3'd4;
  localparam logic [2:0] CMD_SET_POWER = 3'd5;

  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_NINE = 8'h39;
  localparam logic [7:0] ASC_S    = 8'h53;
  localparam logic [7:0] ASC_P    = 8'h50;
  localparam logic [7:0] ASC_C    = 8'h43;
  localparam logic [7:0] ASC_T    = 8'h54;
  localparam logic [7:0] ASC_L    = 8'h4C;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_POP,
    RD_CAP
  } rd_state_t;

  typedef enum logic [1:0] {
    PS_EXP_CMD,
    PS_ARG,
    PS_EXP_TERM,
    PS_DISCARD
  } parse_state_t;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_ZERO) && (b <= ASC_NINE);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Bus between the receive FIFO, the command parser and the control FSM.
// Handshake: rd_uart is a one-cycle pulse issued only while rx_empty is low; r_data
// is valid the cycle after it. cmd_valid and err are one-cycle pulses, never together.
interface uart_cmd_parser_if #(
  parameter int DBIT = 8
);
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            cmd_valid;
  logic [2:0]      cmd_code;
  logic [6:0]      time_min;
  logic [5:0]      time_sec;
  logic [3:0]      power;
  logic            err;

  modport master (
    input  rx_empty, r_data,
    output rd_uart, cmd_valid, cmd_code, time_min, time_sec, power, err
  );

  modport slave (
    output rx_empty, r_data,
    input  rd_uart, cmd_valid, cmd_code, time_min, time_sec, power, err
  );
endinterface

// File: rtl/uart_cmd_parser_idle_timer.sv
// Idle counter that abandons a stalled partial line; done pulses when the count
// would reach TIMEOUT.
module cmd_idle_timer #(
  parameter int TW      = 24,
  parameter int TIMEOUT = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + TW'(1);
    end
  end

  assign done = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Line-oriented ASCII command parser between the UART receive FIFO and the
// microwave control FSM. Define CMD_LOWERCASE_EN to accept lowercase command letters.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 10_000_000,
  parameter int TW      = 24
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_parser_if.master   bus,
  output rd_state_t           dbg_rd_state,
  output parse_state_t        dbg_parse_state
);

  rd_state_t rd_state, rd_next;
  logic      rd_uart_q;
  logic      cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      rd_uart_q <= 1'b0;
    end else begin
      rd_state  <= rd_next;
      rd_uart_q <= (rd_next == RD_POP);
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (!bus.rx_empty) rd_next = RD_POP;
      RD_POP:  rd_next = RD_CAP;
      RD_CAP:  rd_next = bus.rx_empty ? RD_IDLE : RD_POP;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign cap         = (rd_state == RD_CAP);
  assign bus.rd_uart = rd_uart_q;

  logic [DBIT-1:0] rx_byte;
  logic [7:0]      ch;
  logic [7:0]      letter;

  assign rx_byte = bus.r_data;
  assign ch      = rx_byte[7:0];
`ifdef CMD_LOWERCASE_EN
  assign letter = (ch >= 8'h61 && ch <= 8'h7A) ? (ch & 8'hDF) : ch;
`else
  assign letter = ch;
`endif

  parse_state_t    ps, ps_n;
  logic [2:0]      cnt_q, cnt_n;
  logic [3:0][3:0] dig_q, dig_n;
  logic [2:0]      pend_q, pend_n;
  logic            valid_q, valid_n, err_q, err_n;
  logic [2:0]      code_q, code_n;
  logic [6:0]      min_q, min_n;
  logic [5:0]      sec_q, sec_n;
  logic [3:0]      pow_q, pow_n;
  logic [2:0]      need;
  logic [6:0]      mins, secs;
  logic            tmr_clr, tmo;

  assign tmr_clr = cap || (ps == PS_EXP_CMD);

  cmd_idle_timer #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (!tmr_clr),
    .done (tmo)
  );

  assign need = (pend_q == CMD_SET_TIME) ? 3'd4 : 3'd1;
  assign mins = 7'(dig_q[0]) * 7'd10 + 7'(dig_q[1]);
  assign secs = 7'(dig_q[2]) * 7'd10 + 7'(dig_q[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps      <= PS_EXP_CMD;
      cnt_q   <= '0;
      dig_q   <= '0;
      pend_q  <= CMD_NONE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= CMD_NONE;
      min_q   <= '0;
      sec_q   <= '0;
      pow_q   <= 4'd9;
    end else begin
      ps      <= ps_n;
      cnt_q   <= cnt_n;
      dig_q   <= dig_n;
      pend_q  <= pend_n;
      valid_q <= valid_n;
      err_q   <= err_n;
      code_q  <= code_n;
      min_q   <= min_n;
      sec_q   <= sec_n;
      pow_q   <= pow_n;
    end
  end

  always_comb begin
    ps_n    = ps;
    cnt_n   = cnt_q;
    dig_n   = dig_q;
    pend_n  = pend_q;
    valid_n = 1'b0;
    err_n   = 1'b0;
    code_n  = code_q;
    min_n   = min_q;
    sec_n   = sec_q;
    pow_n   = pow_q;
    if (cap) begin
      case (ps)
        PS_EXP_CMD: begin
          if (!is_term(ch)) begin
            cnt_n = '0;
            case (letter)
              ASC_S: begin pend_n = CMD_START;     ps_n = PS_EXP_TERM; end
              ASC_P: begin pend_n = CMD_PAUSE;     ps_n = PS_EXP_TERM; end
              ASC_C: begin pend_n = CMD_CANCEL;    ps_n = PS_EXP_TERM; end
              ASC_T: begin pend_n = CMD_SET_TIME;  ps_n = PS_ARG;      end
              ASC_L: begin pend_n = CMD_SET_POWER; ps_n = PS_ARG;      end
              default: begin err_n = 1'b1; ps_n = PS_DISCARD; end
            endcase
          end
        end
        PS_ARG: begin
          if (is_digit(ch)) begin
            dig_n[cnt_q[1:0]] = ch[3:0];
            cnt_n = cnt_q + 3'd1;
            if (cnt_n == need) ps_n = PS_EXP_TERM;
          end else begin
            // A premature terminator ends the line itself, so no discard is needed.
            err_n = 1'b1;
            cnt_n = '0;
            ps_n  = is_term(ch) ? PS_EXP_CMD : PS_DISCARD;
          end
        end
        PS_EXP_TERM: begin
          if (is_term(ch)) begin
            ps_n = PS_EXP_CMD;
            if (pend_q == CMD_SET_TIME && secs > 7'd59) begin
              err_n = 1'b1;
            end else if (pend_q == CMD_SET_POWER && dig_q[0] == 4'd0) begin
              err_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              code_n  = pend_q;
              if (pend_q == CMD_SET_TIME) begin
                min_n = mins;
                sec_n = secs[5:0];
              end
              if (pend_q == CMD_SET_POWER) pow_n = dig_q[0];
            end
          end else begin
            err_n = 1'b1;
            ps_n  = PS_DISCARD;
          end
        end
        PS_DISCARD: if (is_term(ch)) ps_n = PS_EXP_CMD;
        default: ps_n = PS_EXP_CMD;
      endcase
    end else if (tmo) begin
      err_n = (ps != PS_DISCARD);
      ps_n  = PS_EXP_CMD;
      cnt_n = '0;
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.err       = err_q;
  assign bus.cmd_code  = code_q;
  assign bus.time_min  = min_q;
  assign bus.time_sec  = sec_q;
  assign bus.power     = pow_q;

  assign dbg_rd_state    = rd_state;
  assign dbg_parse_state = ps;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a FIFO model feeds directed and random command lines,
// and a line-level reference model predicts every cmd_valid/err pulse.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.DBIT(8)) bus ();
  rd_state_t    dbg_rd;
  parse_state_t dbg_ps;

  uart_cmd_parser #(
    .DBIT    (8),
    .TIMEOUT (TMO),
    .TW      (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .dbg_rd_state    (dbg_rd),
    .dbg_parse_state (dbg_ps)
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0, pop_cnt = 0, last_pop_step = 0, ev_step = 0;
  int valid_cnt = 0, err_cnt = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  line_q[$];
  logic [20:0] exp_q[$];

  logic [2:0] m_code;
  logic [6:0] m_min;
  logic [5:0] m_sec;
  logic [3:0] m_pow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: FIFO pops on the edge that ends an rd_uart cycle; outputs sampled #1 later.
  task automatic step();
    logic        pop;
    logic [20:0] obs;
    pop = bus.rd_uart;
    @(posedge clk);
    #1;
    step_no++;
    if (pop === 1'b1) begin
      check("pop_while_nonempty", fifo_q.size() > 0, 1);
      pop_cnt++;
      last_pop_step = step_no;
      if (fifo_q.size() > 0) bus.r_data = fifo_q.pop_front();
    end
    bus.rx_empty = (fifo_q.size() == 0);
    if (bus.cmd_valid === 1'b1 || bus.err === 1'b1) begin
      obs = {bus.err, bus.cmd_code, bus.time_min, bus.time_sec, bus.power};
      check("valid_err_exclusive", bus.cmd_valid & bus.err, 0);
      ev_step = step_no;
      if (bus.err === 1'b1) err_cnt++;
      else valid_cnt++;
      if (exp_q.size() == 0) check("event_expected", exp_q.size() > 0, 1);
      else check("event", obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [7:0] upc(input logic [7:0] b);
`ifdef CMD_LOWERCASE_EN
    if (b >= "a" && b <= "z") return b - 8'd32;
`endif
    return b;
  endfunction

  function automatic bit dig(input logic [7:0] b);
    return b >= "0" && b <= "9";
  endfunction

  // A whole line either matches one command form with legal values, or earns one err.
  task automatic model_line();
    logic [7:0] c0;
    int n, mm, ss;
    bit ok;
    if (line_q.size() == 0) return;
    n  = line_q.size();
    c0 = upc(line_q[0]);
    ok = 0;
    if (n == 1 && (c0 == "S" || c0 == "P" || c0 == "C")) begin
      ok = 1;
      m_code = (c0 == "S") ? 3'd1 : (c0 == "P") ? 3'd2 : 3'd3;
    end else if (c0 == "T" && n == 5 && dig(line_q[1]) && dig(line_q[2]) &&
                 dig(line_q[3]) && dig(line_q[4])) begin
      mm = (int'(line_q[1]) - 48) * 10 + (int'(line_q[2]) - 48);
      ss = (int'(line_q[3]) - 48) * 10 + (int'(line_q[4]) - 48);
      if (ss < 60) begin
        ok = 1;
        m_code = 3'd4;
        m_min = mm[6:0];
        m_sec = ss[5:0];
      end
    end else if (c0 == "L" && n == 2 && dig(line_q[1]) && line_q[1] != "0") begin
      ok = 1;
      m_code = 3'd5;
      m_pow = line_q[1][3:0];
    end
    exp_q.push_back({!ok, m_code, m_min, m_sec, m_pow});
    line_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    bus.rx_empty = 1'b0;
    if (b == 8'h0D || b == 8'h0A) model_line();
    else line_q.push_back(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s.getc(i));
  endtask

  task automatic drain(input int extra);
    int guard;
    guard = 0;
    while (fifo_q.size() > 0 && guard < 5000) begin
      step();
      guard++;
    end
    check("drain_bound", guard < 5000, 1);
    repeat (extra) step();
  endtask

  task automatic model_reset();
    m_code = 3'd0;
    m_min  = 7'd0;
    m_sec  = 6'd0;
    m_pow  = 4'd9;
    line_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_uart", bus.rd_uart, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_cmd_code", bus.cmd_code, 0);
    check("rst_time_min", bus.time_min, 0);
    check("rst_time_sec", bus.time_sec, 0);
    check("rst_power", bus.power, 9);
  endtask

  task automatic rand_line();
    logic [7:0] letters[5];
    logic [7:0] q[$];
    int kind;
    letters = '{"S", "P", "C", "T", "L"};
    kind = $urandom_range(0, 7);
    case (kind)
      0: q.push_back(letters[$urandom_range(0, 2)]);
      1: begin
        q.push_back("T");
        repeat (4) q.push_back(8'(48 + $urandom_range(0, 9)));
      end
      2: begin
        q.push_back("L");
        q.push_back(8'(48 + $urandom_range(0, 9)));
      end
      3: begin
        int k;
        k = $urandom_range(0, 4);
        q.push_back(letters[k] | 8'h20);
        if (k == 3) repeat (4) q.push_back(8'(48 + $urandom_range(0, 9)));
        if (k == 4) q.push_back(8'(48 + $urandom_range(1, 9)));
      end
      4: begin
        q.push_back(8'($urandom_range(33, 126)));
        repeat ($urandom_range(0, 2)) q.push_back(8'(48 + $urandom_range(0, 9)));
      end
      5: begin
        q.push_back("T");
        repeat ($urandom_range(0, 3)) q.push_back(8'(48 + $urandom_range(0, 9)));
      end
      6: begin
        q.push_back(letters[$urandom_range(0, 2)]);
        q.push_back(8'($urandom_range(33, 126)));
      end
      default: ;
    endcase
    foreach (q[i]) send(q[i]);
    send($urandom_range(0, 1) ? 8'h0D : 8'h0A);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, wait_n;
    rst = 1'b1;
    bus.rx_empty = 1'b1;
    bus.r_data = 8'h00;
    model_reset();
    repeat (3) step();
    check_reset_outputs();
    rst = 1'b0;
    step();

    // Basic SET_TIME
    pop_cnt = 0; v0 = valid_cnt; e0 = err_cnt;
    send_str("T0130\r");
    drain(4);
    check("t0130_pops", pop_cnt, 6);
    check("t0130_valids", valid_cnt - v0, 1);
    check("t0130_errs", err_cnt - e0, 0);

    // Back-to-back SET_POWER then START
    v0 = valid_cnt; e0 = err_cnt;
    send_str("L5\n");
    send_str("S\r");
    drain(4);
    check("l5_s_valids", valid_cnt - v0, 2);
    check("l5_s_errs", err_cnt - e0, 0);

    // Out-of-range seconds and power 0
    v0 = valid_cnt; e0 = err_cnt;
    send_str("T0175\r");
    send_str("L0\r");
    drain(4);
    check("bad_args_errs", err_cnt - e0, 2);
    check("bad_args_valids", valid_cnt - v0, 0);

    // Bad command letter then a good line
    v0 = valid_cnt; e0 = err_cnt;
    send_str("X12\r");
    send_str("P\r");
    drain(4);
    check("x12_errs", err_cnt - e0, 1);
    check("x12_valids", valid_cnt - v0, 1);

    // Stalled partial line times out TIMEOUT cycles after its last byte is captured
    e0 = err_cnt;
    send_str("T01");
    exp_q.push_back({1'b1, m_code, m_min, m_sec, m_pow});
    line_q.delete();
    drain(2);
    wait_n = 0;
    while (err_cnt == e0 && wait_n < TMO + 20) begin
      step();
      wait_n++;
    end
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_latency", ev_step - (last_pop_step + 1), TMO);
    v0 = valid_cnt;
    send_str("C\r");
    drain(4);
    check("after_timeout_valid", valid_cnt - v0, 1);
    check("after_timeout_errs", err_cnt - e0, 1);

    // Reset mid-line drops it silently
    send_str("L7\r");
    send_str("T01");
    drain(3);
    rst = 1'b1;
    step();
    check_reset_outputs();
    rst = 1'b0;
    model_reset();
    check("exp_empty_at_reset", exp_q.size(), 0);
    v0 = valid_cnt; e0 = err_cnt;
    send_str("C\r");
    drain(4);
    check("after_reset_valid", valid_cnt - v0, 1);
    check("after_reset_errs", err_cnt - e0, 0);

    // Random lines against the line-level model
    repeat (80) begin
      rand_line();
      repeat ($urandom_range(0, 3)) step();
    end
    drain(6);
    check("all_events_seen", exp_q.size(), 0);
    check("final_code", bus.cmd_code, m_code);
    check("final_min", bus.time_min, m_min);
    check("final_sec", bus.time_sec, m_sec);
    check("final_power", bus.power, m_pow);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes bytes from the UART receive FIFO (standard-read FIFO: `dout` valid the cycle after `rd_en`).
- Parses line-oriented ASCII microwave commands and emits one decoded command pulse per valid line, with its arguments.
- Sits between the UART receive top and the microwave control FSM.
- Malformed lines and stalled partial lines raise an error pulse and are discarded.

Parameters:
- DBIT, 8, byte width; must match the UART data width.
- TIMEOUT, 10_000_000, idle cycles allowed between bytes within a partial line before it is abandoned (100 ms at 100 MHz).
- TW, 24, width of the timeout counter; TIMEOUT must be < 2^TW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- rx_empty  in  1  receive FIFO empty
- r_data  in  DBIT  receive FIFO read data, valid the cycle after rd_uart
- rd_uart  out  1  receive FIFO read enable; one-cycle pulse per byte
- cmd_valid  out  1  one-cycle pulse; cmd_code and its argument are valid
- cmd_code  out  3  1=START 2=PAUSE 3=CANCEL 4=SET_TIME 5=SET_POWER; 0 after reset
- time_min  out  7  minutes 0-99; updated only by a valid SET_TIME
- time_sec  out  6  seconds 0-59; updated only by a valid SET_TIME
- power  out  4  power level 1-9; updated only by a valid SET_POWER
- err  out  1  one-cycle pulse; line rejected

Behaviour:
- Reset values: rd_uart=0, cmd_valid=0, err=0, cmd_code=0, time_min=0, time_sec=0, power=9.
- Reset state: read FSM in IDLE, parser in EXP_CMD, all digit registers cleared, timeout counter cleared.
- Reset mid-line drops the partial line and emits no err.

Read FSM (IDLE, POP, CAP):
- IDLE: if !rx_empty, go to POP.
- POP: rd_uart=1 for exactly this cycle.
- CAP: sample r_data and process it.
  - If !rx_empty, go to POP; else go to IDLE.
  - Throughput: one byte per 2 cycles.
- All outputs are registered. cmd_valid or err is high in the cycle after the CAP that consumed the deciding byte.

Parser FSM (terminator T = 0x0D or 0x0A; digits = 0x30-0x39):
- EXP_CMD:
  - T is ignored (empty lines allowed).
  - 'S', 'P' or 'C' → EXP_TERM.
  - 'T' → ARG, need=4.
  - 'L' → ARG, need=1.
  - Any other byte → err, then DISCARD.
- ARG:
  - Digit: store it and increment the count; when count==need → EXP_TERM.
  - T → err, then EXP_CMD.
  - Any other byte → err, then DISCARD.
- EXP_TERM:
  - T → validate and emit cmd_valid, then EXP_CMD.
  - Any other byte → err, then DISCARD.
- DISCARD: consume bytes until T, then EXP_CMD. No further err for that line.

Validation on terminator:
- SET_TIME: minutes = d0*10+d1 and seconds = d2*10+d3, both computed in 7 bits.
  - seconds > 59 → err, no cmd_valid, outputs unchanged.
  - Otherwise load time_min and time_sec (seconds truncated to 6 bits).
- SET_POWER: digit 0 → err; digits 1-9 load power.
- cmd_valid and err are never asserted in the same cycle.
- Argument outputs hold their values across other commands.

Timeout:
- The counter clears on every CAP and whenever the parser is in EXP_CMD.
- Otherwise it increments each cycle.
- Reaching TIMEOUT: err pulse, parser → EXP_CMD, digit count cleared.
- DISCARD also times out, but emits no second err.

Optional Feature:
- CMD_LOWERCASE_EN defined: 's', 'p', 'c', 't', 'l' are accepted as equivalent to the uppercase command letters.
- CMD_LOWERCASE_EN undefined: lowercase command letters → err, DISCARD.

Decomposition:
- Package uart_cmd_pkg holds:
  - CMD_* code constants;
  - ASCII constants (CR, LF, digit base, command letters);
  - read FSM and parser FSM state enums.
- One natural sub-module: cmd_idle_timer (TW-bit counter; clear, enable, done pulse at TIMEOUT).

Test Plan:
- FIFO supplies "T0130\r" → 6 rd_uart pulses; one cmd_valid with cmd_code=4, time_min=1, time_sec=30; err never asserted.
- "L5\n" then "S\r" back-to-back → cmd_valid power=5 code=5, then cmd_valid code=1; time_min/time_sec unchanged at reset 0.
- "T0175\r" → err once, no cmd_valid, time_sec unchanged; "L0\r" → err, power stays 9.
- "X12\r" then "P\r" → single err; "1", "2", "\r" discarded; then cmd_valid code=2.
- "T01" then no bytes for TIMEOUT cycles (bench TIMEOUT=50) → err exactly at count 50; next "C\r" → cmd_valid code=3.
- rst asserted after "T01" received → all outputs at reset values next cycle; then "C\r" → cmd_valid code=3, no err.
